csr_traversal: RTL and testbench

- Dual-stream automaton traversal engine for regex matching.
- Walks a transition table stored in CSR (compressed sparse row) form in an external 512-bit-wide single-port block RAM. The RAM model has a 17-bit address and 1-cycle registered read.
- Consumes two byte streams in lock-step, one character per stream per request, and keeps an independent current state and match counter for each stream.
- Sits between the character-trace source and the BRAM wrapper; the only memory traffic is reads.

---
 rtl/csr_traversal.sv | 190 +++++++++++++++++++
 tb/tb_csr_traversal.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/csr_traversal.sv
// Two-stream automaton walker over a CSR transition table held in a 512-bit BRAM.
// Each character pair is looked up stream 1 first, then stream 2, sharing one read port.
module csr_traversal #(
  parameter int ENTRIES = 16,
  parameter int ROOT    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [23:0]            size,
  output logic [16:0]            rd_address,
  input  logic [32*ENTRIES-1:0]  rd_bus,
  output logic                   input_char_flag,
  input  logic [7:0]             input_char,
  input  logic [7:0]             input_char_2,
  output logic                   match_1,
  output logic                   match_2,
  output logic [31:0]            match_count_1,
  output logic [31:0]            match_count_2
);

  typedef enum logic [2:0] {
    S_REQ, S_LOAD, S_RD1, S_WAIT1, S_EVAL1, S_RD2, S_WAIT2, S_EVAL2
  } state_t;

  localparam logic [16:0] ROOT_A = 17'(ROOT);

  state_t      state_q, state_d;
  logic [16:0] st1_q, st1_d, st2_q, st2_d;
  logic [16:0] scan_q, scan_d;
  logic [16:0] rd_addr_q, rd_addr_d;
  logic [7:0]  ch1_q, ch1_d, ch2_q, ch2_d;
  logic        retried_q, retried_d;
  logic        inv_q, inv_d;
  logic        m1_q, m1_d, m2_q, m2_d;
  logic [31:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

  logic        sec;
  logic [16:0] cur_st;
  logic [7:0]  cur_ch;
  logic        hit, hit_acc, live;
  logic [16:0] hit_next;
  logic        scan_in_range, next_in_range, cont_in_range;
  logic        take, fail;
  logic [16:0] new_st;
  logic        unused_rd_bus;

  assign sec    = (state_q == S_RD2) || (state_q == S_WAIT2) || (state_q == S_EVAL2);
  assign cur_st = sec ? st2_q : st1_q;
  assign cur_ch = sec ? ch2_q : ch1_q;

  // Lowest-index valid entry with a matching char wins; the first invalid entry closes the row.
  always_comb begin
    hit      = 1'b0;
    hit_acc  = 1'b0;
    hit_next = '0;
    live     = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (live && !hit) begin
        if (!rd_bus[32*i+31]) begin
          live = 1'b0;
        end else if (rd_bus[32*i+17 +: 8] == cur_ch) begin
          hit      = 1'b1;
          hit_acc  = rd_bus[32*i+29];
          hit_next = rd_bus[32*i +: 17];
        end
      end
    end
  end

  assign unused_rd_bus = ^rd_bus;

  assign scan_in_range = {7'b0, scan_q} < size;
  assign next_in_range = {7'b0, hit_next} < size;
  assign cont_in_range = ({7'b0, scan_q} + 24'd1) < size;

  always_comb begin
    state_d   = state_q;
    st1_d     = st1_q;
    st2_d     = st2_q;
    scan_d    = scan_q;
    rd_addr_d = rd_addr_q;
    ch1_d     = ch1_q;
    ch2_d     = ch2_q;
    retried_d = retried_q;
    inv_d     = inv_q;
    m1_d      = 1'b0;
    m2_d      = 1'b0;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    take      = 1'b0;
    fail      = 1'b0;
    new_st    = ROOT_A;

    case (state_q)
      S_REQ:  state_d = S_LOAD;
      S_LOAD: begin
        ch1_d     = input_char;
        ch2_d     = input_char_2;
        scan_d    = st1_q;
        retried_d = 1'b0;
        state_d   = S_RD1;
      end
      // An out-of-range scan address skips the read but still spends the wait/eval slots.
      S_RD1, S_RD2: begin
        inv_d = ~scan_in_range;
        if (scan_in_range) rd_addr_d = scan_q;
        state_d = sec ? S_WAIT2 : S_WAIT1;
      end
      S_WAIT1: state_d = S_EVAL1;
      S_WAIT2: state_d = S_EVAL2;
      S_EVAL1, S_EVAL2: begin
        if (!inv_q && hit && next_in_range) begin
          take = 1'b1;
        end else if (!inv_q && live && !hit && cont_in_range) begin
          scan_d  = scan_q + 17'd1;
          state_d = sec ? S_RD2 : S_RD1;
        end else begin
          fail = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (fail && (cur_st != ROOT_A) && !retried_q) begin
      scan_d    = ROOT_A;
      retried_d = 1'b1;
      state_d   = sec ? S_RD2 : S_RD1;
    end else if (take || fail) begin
      new_st = take ? hit_next : ROOT_A;
      if (sec) begin
        st2_d = new_st;
        if (take && hit_acc) begin
          m2_d   = 1'b1;
          cnt2_d = cnt2_q + 32'd1;
        end
        state_d = S_REQ;
      end else begin
        st1_d = new_st;
        if (take && hit_acc) begin
          m1_d   = 1'b1;
          cnt1_d = cnt1_q + 32'd1;
        end
        scan_d    = st2_q;
        retried_d = 1'b0;
        state_d   = S_RD2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_REQ;
      st1_q     <= ROOT_A;
      st2_q     <= ROOT_A;
      scan_q    <= ROOT_A;
      rd_addr_q <= '0;
      ch1_q     <= '0;
      ch2_q     <= '0;
      retried_q <= 1'b0;
      inv_q     <= 1'b0;
      m1_q      <= 1'b0;
      m2_q      <= 1'b0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
    end else begin
      state_q   <= state_d;
      st1_q     <= st1_d;
      st2_q     <= st2_d;
      scan_q    <= scan_d;
      rd_addr_q <= rd_addr_d;
      ch1_q     <= ch1_d;
      ch2_q     <= ch2_d;
      retried_q <= retried_d;
      inv_q     <= inv_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
    end
  end

  // Gated by reset so the request appears in the very cycle reset is released.
  assign input_char_flag = (state_q == S_REQ) && reset;
  assign rd_address      = rd_addr_q;
  assign match_1         = m1_q;
  assign match_2         = m2_q;
  assign match_count_1   = cnt1_q;
  assign match_count_2   = cnt2_q;

endmodule

// File: tb/tb_csr_traversal.sv
// Directed bench for csr_traversal: a registered-read BRAM model and hand-computed
// per-pair cycle counts, read addresses, match pulses and counts.
module tb_csr_traversal;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [23:0]  size;
  logic [16:0]  rd_address;
  logic [511:0] rd_bus;
  logic         input_char_flag;
  logic [7:0]   input_char, input_char_2;
  logic         match_1, match_2;
  logic [31:0]  match_count_1, match_count_2;

  logic [511:0] mem [0:63];
  logic [16:0]  tr [0:127];
  int tests = 0;
  int failed = 0;
  int p_cyc, p_m1, p_m2, p_both;

  csr_traversal #(.ENTRIES(16), .ROOT(0)) dut (
    .clk(clk), .reset(reset), .size(size), .rd_address(rd_address), .rd_bus(rd_bus),
    .input_char_flag(input_char_flag), .input_char(input_char), .input_char_2(input_char_2),
    .match_1(match_1), .match_2(match_2),
    .match_count_1(match_count_1), .match_count_2(match_count_2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_bus <= (rd_address < 17'd64) ? mem[rd_address[5:0]] : '0;

  function automatic logic [31:0] ent(input logic acc, input logic [7:0] ch, input logic [16:0] nxt);
    return {1'b1, 1'b0, acc, 4'b0, ch, nxt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called during a REQ cycle; runs until the next REQ (bounded), tracing rd_address per cycle.
  task automatic pair(input logic [7:0] c1, input logic [7:0] c2);
    input_char = c1;
    input_char_2 = c2;
    p_cyc = 0; p_m1 = 0; p_m2 = 0; p_both = 0;
    do begin
      @(posedge clk); #1;
      p_cyc++;
      tr[p_cyc[6:0]] = rd_address;
      if (match_1) p_m1++;
      if (match_2) p_m2++;
      if (match_1 && match_2) p_both++;
    end while (!input_char_flag && p_cyc < 100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    size = 24'd7;
    input_char = 8'h00;
    input_char_2 = 8'h00;
    for (int w = 0; w < 64; w++) mem[w] = '0;
    mem[0][31:0] = ent(1'b1, 8'h61, 17'd3);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_address", 32'(rd_address), 32'd0);
    chk("rst_flag", 32'(input_char_flag), 32'd0);
    chk("rst_match", 32'({match_1, match_2}), 32'd0);
    chk("rst_count_1", match_count_1, 32'd0);
    chk("rst_count_2", match_count_2, 32'd0);
    reset = 1'b1;
    #1;
    chk("first_req_flag", 32'(input_char_flag), 32'd1);

    // single accepting transition on both streams
    pair(8'h61, 8'h61);
    chk("A_period", p_cyc, 8);
    chk("A_addr1", 32'(tr[3]), 32'd0);
    chk("A_addr2", 32'(tr[6]), 32'd0);
    chk("A_m1", p_m1, 1);
    chk("A_m2", p_m2, 1);
    chk("A_overlap", p_both, 0);
    chk("A_count_1", match_count_1, 32'd1);
    chk("A_count_2", match_count_2, 32'd1);

    // both streams at state 3 miss, retry at root once
    mem[0][31:0] = ent(1'b1, 8'h61, 17'd4);
    mem[3][31:0] = ent(1'b0, 8'h62, 17'd5);
    pair(8'h61, 8'h7a);
    chk("B_period", p_cyc, 14);
    chk("B_addr1a", 32'(tr[3]), 32'd3);
    chk("B_addr1b", 32'(tr[6]), 32'd0);
    chk("B_addr2a", 32'(tr[9]), 32'd3);
    chk("B_addr2b", 32'(tr[12]), 32'd0);
    chk("B_m1", p_m1, 1);
    chk("B_m2", p_m2, 0);
    chk("B_count_1", match_count_1, 32'd2);
    chk("B_count_2", match_count_2, 32'd1);

    // stream 1 misses from state 4; stream 2 matches root entry whose next is beyond size
    mem[0][63:32] = ent(1'b0, 8'h63, 17'd9);
    pair(8'h00, 8'h63);
    chk("C_period", p_cyc, 11);
    chk("C_addr1a", 32'(tr[3]), 32'd4);
    chk("C_addr1b", 32'(tr[6]), 32'd0);
    chk("C_addr2", 32'(tr[9]), 32'd0);
    chk("C_m", 32'(p_m1 + p_m2), 32'd0);
    chk("C_count_1", match_count_1, 32'd2);
    chk("C_count_2", match_count_2, 32'd1);

    // full root word continues into word 1
    for (int i = 2; i < 16; i++) mem[0][32*i +: 32] = ent(1'b0, 8'(8'h70 + i), 17'd5);
    mem[1][31:0] = ent(1'b0, 8'h62, 17'd2);
    pair(8'h62, 8'h61);
    chk("D_period", p_cyc, 11);
    chk("D_addr1a", 32'(tr[3]), 32'd0);
    chk("D_addr1b", 32'(tr[6]), 32'd1);
    chk("D_addr2", 32'(tr[9]), 32'd0);
    chk("D_m1", p_m1, 0);
    chk("D_m2", p_m2, 1);
    chk("D_count_2", match_count_2, 32'd2);

    // stream 1 from 2 retries to root; stream 2 from 4 retries and walks the continued root row
    pair(8'h61, 8'h00);
    chk("E_period", p_cyc, 17);
    chk("E_addr1a", 32'(tr[3]), 32'd2);
    chk("E_addr1b", 32'(tr[6]), 32'd0);
    chk("E_addr2a", 32'(tr[9]), 32'd4);
    chk("E_addr2b", 32'(tr[12]), 32'd0);
    chk("E_addr2c", 32'(tr[15]), 32'd1);
    chk("E_m1", p_m1, 1);
    chk("E_count_1", match_count_1, 32'd3);
    chk("E_count_2", match_count_2, 32'd2);

    // reset during WAIT1
    input_char = 8'h61;
    input_char_2 = 8'h61;
    repeat (3) @(posedge clk);
    #1;
    chk("R_wait1_addr", 32'(rd_address), 32'd4);
    reset = 1'b0;
    #1;
    chk("R_count_1", match_count_1, 32'd0);
    chk("R_count_2", match_count_2, 32'd0);
    chk("R_addr", 32'(rd_address), 32'd0);
    chk("R_flag", 32'(input_char_flag), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("R_req_flag", 32'(input_char_flag), 32'd1);

    pair(8'h61, 8'h62);
    chk("F_period", p_cyc, 11);
    chk("F_addr1", 32'(tr[3]), 32'd0);
    chk("F_addr2a", 32'(tr[6]), 32'd0);
    chk("F_addr2b", 32'(tr[9]), 32'd1);
    chk("F_m1", p_m1, 1);
    chk("F_count_1", match_count_1, 32'd1);
    chk("F_count_2", match_count_2, 32'd0);

    // size=1: continuation and next-state both out of range
    reset = 1'b0;
    size = 24'd1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    pair(8'h62, 8'h61);
    chk("G_period", p_cyc, 8);
    chk("G_m", 32'(p_m1 + p_m2), 32'd0);
    chk("G_count_2", match_count_2, 32'd0);

    // size=0: every lookup misses without a read
    reset = 1'b0;
    size = 24'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    pair(8'h61, 8'h61);
    chk("H_period", p_cyc, 8);
    chk("H_m", 32'(p_m1 + p_m2), 32'd0);
    chk("H_count_1", match_count_1, 32'd0);
    chk("H_addr", 32'(tr[3]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
